gate_trace_logger: RTL and testbench

Hardware monitor placed directly downstream of a logic-gate stage (e.g. not_gate). It samples the gate's input `a` and output `y` every clock and records a timestamped entry whenever the pair changes. Entries are buffered in an internal FIFO and drained over a valid/ready stream toward a file/UART writer. It is the synthesizable counterpart of the bench-side monitor log.

---
 rtl/gate_trace_logger_pkg.sv | 19 +
 rtl/gate_trace_logger_if.sv | 16 +
 rtl/gate_trace_logger_sync_fifo.sv | 62 ++++++
 rtl/gate_trace_logger.sv | 98 +++++++++
 tb/tb_gate_trace_logger.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_trace_logger_pkg.sv
// Shared constants and helpers for the gate trace logger.
//   DEF_DATA_W / DEF_TS_W / DEF_DEPTH : default sizing of the logger
//   DROP_SAT                          : saturation value of the drop counter
//   entry_w()                         : width of one {ts, a, y} trace entry
package gate_trace_logger_pkg;

   localparam int DEF_DATA_W = 1;
   localparam int DEF_TS_W   = 16;
   localparam int DEF_DEPTH  = 8;

   localparam logic [7:0] DROP_SAT = 8'd255;

   function automatic int entry_w(input int ts_w, input int data_w);
      return ts_w + 2 * data_w;
   endfunction

   localparam int ENTRY_W = entry_w(DEF_TS_W, DEF_DATA_W);

endpackage

// File: rtl/gate_trace_logger_if.sv
// Trace entry stream between the logger and its consumer.
// Handshake: out_data is transferred at a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the source holds
// out_data unchanged. out_ready may be high while out_valid=0; nothing moves.
//   master : source side (drives out_valid, out_data; reads out_ready)
//   slave  : consumer side
interface gate_trace_logger_if #(
   parameter int W = gate_trace_logger_pkg::ENTRY_W
);
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/gate_trace_logger_sync_fifo.sv
// Synchronous FIFO with registered pointers and a register-array store.
//   clk, rst : clock, synchronous active-high reset
//   flush    : synchronous empty (contents discarded)
//   push/din : write request and data (accepted when not full, or when full
//              and a pop happens in the same cycle)
//   pop/dout : read request and head data (dout is 0 while empty)
//   count    : occupancy, full, empty : status flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle;
   // the write slot then equals the slot being vacated.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wr_ptr] <= din;
   end

   assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/gate_trace_logger.sv
// Monitor for a logic-gate stage: samples the gate input a and output y
// every clock and queues a timestamped {ts, a, y} entry whenever the pair
// changes (or as a first snapshot after enabling). Entries drain over a
// valid/ready stream.
//   clk, rst   : clock, synchronous active-high reset
//   en         : capture enable (also gates the timestamp counter)
//   clr        : flush FIFO and statistics, timestamp kept
//   a, y       : monitored gate signals
//   stream     : entry stream (out_valid / out_ready / out_data)
//   count      : FIFO occupancy
//   overflow   : sticky, an entry was dropped
//   drop_count : dropped entries, saturating at 255
module gate_trace_logger
   import gate_trace_logger_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TS_W   = DEF_TS_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clr,
   input  logic [DATA_W-1:0]       a,
   input  logic [DATA_W-1:0]       y,
   gate_trace_logger_if.master     stream,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [7:0]              drop_count
);

   localparam int EW = entry_w(TS_W, DATA_W);

   logic [TS_W-1:0]   ts;
   logic [DATA_W-1:0] prev_a;
   logic [DATA_W-1:0] prev_y;
   logic              primed;
   logic              evt;
   logic              push_req;
   logic              pop_req;
   logic              push_ok;
   logic              full;
   logic              empty;
   logic [EW-1:0]     entry;

   // An unprimed enable always logs, so every enable window starts with a
   // snapshot of the current a/y pair.
   assign evt      = en && (!primed || (a != prev_a) || (y != prev_y));
   assign push_req = evt && !clr;
   assign pop_req  = stream.out_valid && stream.out_ready && !clr;
   assign push_ok  = !full || pop_req;
   assign entry    = {ts, a, y};

   assign stream.out_valid = !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts         <= '0;
         prev_a     <= '0;
         prev_y     <= '0;
         primed     <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (en) ts <= ts + 1'b1;
         prev_a <= a;
         prev_y <= y;
         if (clr) begin
            primed     <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
         end else begin
            primed <= en;
            if (push_req && !push_ok) begin
               overflow <= 1'b1;
               if (drop_count != DROP_SAT) drop_count <= drop_count + 1'b1;
            end
         end
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clr),
      .push  (push_req),
      .pop   (pop_req),
      .din   (entry),
      .dout  (stream.out_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_gate_trace_logger.sv
module tb_gate_trace_logger;

   localparam int ENTRY_W  = 18;
   localparam int ENTRY4_W = 6;
   localparam int DEPTH    = 8;

   logic clk;
   logic rst;
   logic en, clr;
   logic [0:0] a, y;
   logic [3:0] count;
   logic       overflow;
   logic [7:0] drop_count;

   logic en4;
   logic [0:0] a4, y4;
   logic [3:0] count4;
   logic       overflow4;
   logic [7:0] drop_count4;

   gate_trace_logger_if #(.W(ENTRY_W))  s_if ();
   gate_trace_logger_if #(.W(ENTRY4_W)) s4_if ();

   gate_trace_logger #(.DATA_W(1), .TS_W(16), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .a          (a),
      .y          (y),
      .stream     (s_if),
      .count      (count),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   gate_trace_logger #(.DATA_W(1), .TS_W(4), .DEPTH(DEPTH)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .en         (en4),
      .clr        (1'b0),
      .a          (a4),
      .y          (y4),
      .stream     (s4_if),
      .count      (count4),
      .overflow   (overflow4),
      .drop_count (drop_count4)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // scoreboard and reference state for the 16-bit-timestamp instance
   logic [ENTRY_W-1:0] exp_q[$];
   logic [15:0]        m_ts;
   logic               m_pa, m_py, m_primed, m_ovf;
   logic [3:0]         m_count;
   logic [7:0]         m_drop;
   logic [ENTRY_W-1:0] first_exp;

   // Apply the currently driven inputs for one clock. Expected entries are
   // pushed when an event is driven and popped/compared when the DUT hands
   // the head entry over.
   task automatic tick();
      logic m_pop, m_ev;
      if (rst) begin
         exp_q.delete();
         m_count = '0; m_ts = '0; m_pa = 0; m_py = 0;
         m_primed = 0; m_ovf = 0; m_drop = '0;
      end else begin
         m_pop = (m_count != 0) && s_if.out_ready && !clr;
         if (m_pop) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_pop: got %0h required no entry", s_if.out_data);
            end else begin
               if (s_if.out_data !== exp_q[0]) begin
                  n_fail++;
                  $display("FAIL sb_data: got %0h required %0h", s_if.out_data, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         m_ev = en && (!m_primed || a[0] != m_pa || y[0] != m_py);
         if (clr) begin
            exp_q.delete();
            m_count = '0; m_ovf = 0; m_drop = '0; m_primed = 0;
         end else begin
            if (m_ev) begin
               if (m_count < DEPTH || m_pop) begin
                  exp_q.push_back({m_ts, a, y});
                  m_count = m_count + 1;
               end else begin
                  m_ovf = 1;
                  if (m_drop != 8'd255) m_drop = m_drop + 1;
               end
            end
            if (m_pop) m_count = m_count - 1;
            m_primed = en;
         end
         m_pa = a[0];
         m_py = y[0];
         if (en) m_ts = m_ts + 1;
      end
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (count !== m_count || s_if.out_valid !== (m_count != 0)) begin
         n_fail++;
         $display("FAIL sb_count: got count=%0d valid=%b required count=%0d", count, s_if.out_valid, m_count);
      end
   endtask

   task automatic test_reset();
      rst = 1; clr = 0; en = 0; a = 0; y = 0; s_if.out_ready = 0;
      en4 = 0; a4 = 0; y4 = 0; s4_if.out_ready = 0;
      tick(); tick();
      rst = 0;
      n_tests++;
      if (s_if.out_valid !== 1'b0 || count !== 4'd0 || s_if.out_data !== '0 ||
          overflow !== 1'b0 || drop_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset: got valid=%b count=%0d data=%0h ovf=%b drop=%0d required all 0",
                  s_if.out_valid, count, s_if.out_data, overflow, drop_count);
      end
   endtask

   task automatic test_snapshot();
      en = 1; a = 0; y = 1;
      tick();
      n_tests++;
      if (s_if.out_valid !== 1'b1 || count !== 4'd1 || s_if.out_data !== {16'd0, 2'b01}) begin
         n_fail++;
         $display("FAIL snapshot: got valid=%b count=%0d data=%0h required 1 1 %0h",
                  s_if.out_valid, count, s_if.out_data, {16'd0, 2'b01});
      end
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (count !== 4'd1) begin
         n_fail++;
         $display("FAIL snapshot_hold: got count=%0d required 1", count);
      end
   endtask

   task automatic test_drain();
      s_if.out_ready = 1;
      for (int i = 0; i < 20 && m_ts != 16'd10; i++) tick();
      a = 1; y = 1;
      tick();
      n_tests++;
      if (s_if.out_data !== {16'd10, 2'b11}) begin
         n_fail++;
         $display("FAIL drain_first: got %0h required %0h", s_if.out_data, {16'd10, 2'b11});
      end
      y = 0;
      tick();
      n_tests++;
      if (s_if.out_data !== {16'd11, 2'b10}) begin
         n_fail++;
         $display("FAIL drain_second: got %0h required %0h", s_if.out_data, {16'd11, 2'b10});
      end
      tick(); tick();
      n_tests++;
      if (count !== 4'd0 || overflow !== 1'b0 || s_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_end: got count=%0d ovf=%b valid=%b required 0 0 0",
                  count, overflow, s_if.out_valid);
      end
   endtask

   task automatic test_overflow();
      s_if.out_ready = 0;
      en = 0;
      tick();
      en = 1;
      for (int i = 0; i < 12; i++) begin
         a = ~a;
         if (i == 0) first_exp = {m_ts, a, y};
         tick();
         n_tests++;
         if (s_if.out_data !== first_exp) begin
            n_fail++;
            $display("FAIL ovf_stable[%0d]: got %0h required %0h", i, s_if.out_data, first_exp);
         end
      end
      n_tests++;
      if (count !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd4) begin
         n_fail++;
         $display("FAIL ovf_stats: got count=%0d ovf=%b drop=%0d required 8 1 4",
                  count, overflow, drop_count);
      end
   endtask

   task automatic test_back_to_back();
      s_if.out_ready = 1;
      a = ~a;
      tick();
      n_tests++;
      if (count !== 4'd8 || drop_count !== 8'd4) begin
         n_fail++;
         $display("FAIL full_pop: got count=%0d drop=%0d required 8 4", count, drop_count);
      end
      for (int i = 0; i < 8; i++) tick();
      n_tests++;
      if (count !== 4'd0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL full_drain: got count=%0d ovf=%b required 0 1", count, overflow);
      end
   endtask

   task automatic test_wrap();
      en = 0; s_if.out_ready = 0;
      en4 = 1; a4 = 0; y4 = 0; s4_if.out_ready = 0;
      for (int i = 0; i < 17; i++) tick();
      a4 = 1;
      tick();
      tick(); tick(); tick();
      n_tests++;
      if (count4 !== 4'd2) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d required 2", count4);
      end
      n_tests++;
      if (s4_if.out_data !== 6'b0000_00) begin
         n_fail++;
         $display("FAIL wrap_snap: got %0h required 0", s4_if.out_data);
      end
      s4_if.out_ready = 1;
      tick();
      n_tests++;
      if (s4_if.out_data !== {4'd1, 2'b10}) begin
         n_fail++;
         $display("FAIL wrap_ts: got %0h required %0h", s4_if.out_data, {4'd1, 2'b10});
      end
      tick();
      n_tests++;
      if (count4 !== 4'd0 || overflow4 !== 1'b0 || drop_count4 !== 8'd0) begin
         n_fail++;
         $display("FAIL wrap_end: got count=%0d ovf=%b drop=%0d required 0 0 0",
                  count4, overflow4, drop_count4);
      end
      en4 = 0;
   endtask

   task automatic test_clr_rst();
      en = 1; s_if.out_ready = 0;
      for (int i = 0; i < 5; i++) begin a = ~a; tick(); end
      n_tests++;
      if (count !== 4'd5) begin
         n_fail++;
         $display("FAIL pre_clr: got count=%0d required 5", count);
      end
      clr = 1; a = ~a;
      tick();
      clr = 0;
      n_tests++;
      if (count !== 4'd0 || overflow !== 1'b0 || drop_count !== 8'd0 || s_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clr: got count=%0d ovf=%b drop=%0d valid=%b required 0 0 0 0",
                  count, overflow, drop_count, s_if.out_valid);
      end
      first_exp = {m_ts, a, y};
      tick();
      n_tests++;
      if (count !== 4'd1 || s_if.out_data !== first_exp || first_exp[17:2] == 16'd0) begin
         n_fail++;
         $display("FAIL clr_snap: got count=%0d data=%0h required 1 %0h", count, s_if.out_data, first_exp);
      end
      for (int i = 0; i < 4; i++) begin a = ~a; tick(); end
      rst = 1; clr = 1;
      tick();
      rst = 0; clr = 0;
      n_tests++;
      if (s_if.out_valid !== 1'b0 || count !== 4'd0 || s_if.out_data !== '0 ||
          overflow !== 1'b0 || drop_count !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_rst: got valid=%b count=%0d data=%0h ovf=%b drop=%0d required all 0",
                  s_if.out_valid, count, s_if.out_data, overflow, drop_count);
      end
      a = 1; y = 0;
      tick();
      n_tests++;
      if (s_if.out_data !== {16'd0, 2'b10}) begin
         n_fail++;
         $display("FAIL rst_ts: got %0h required %0h", s_if.out_data, {16'd0, 2'b10});
      end
   endtask

   initial begin
      test_reset();
      test_snapshot();
      test_drain();
      test_overflow();
      test_back_to_back();
      test_wrap();
      test_clr_rst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
